// File: rtl/uart_hskbus_mux.sv
// uart_hskbus_mux: housekeeping UART fan-out/fan-in between one host UART and NCHAN
// responder lines.
//
// Host TX is broadcast to every tx-enabled channel. The rx-enabled responder lines are
// wire-ANDed into host RX. Each line (host and every channel) has a start-bit detector
// with holdoff that counts bytes. Two rx-enabled responders talking at once is flagged as
// a collision.
//
// Optional feature: define UART_HSKBUS_STUCK_DET_EN to build stuck-low detection. A
// channel held low for STUCK_CLKS cycles sets a sticky flag and is masked from the merge.
// Without the macro, stuck_o is 0, stuck_clr_i is ignored and no channel is ever masked.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   hskbus_tx_i      host UART TX (async, idle high)
//   hskbus_rx_o      merged responder data to host RX (registered)
//   ch_rx_i          responder TX lines (async, idle high)
//   ch_tx_o          broadcast host data to responders (registered)
//   tx_en_i/rx_en_i  per-channel broadcast / merge enables
//   stuck_clr_i      single-cycle clear of sticky stuck flags
//   tx_bytes_o       host start bits counted
//   rx_bytes_o       per-channel start bits, channel k at [k*CNT_WIDTH +: CNT_WIDTH]
//   collision_o      one-cycle pulse per collision cycle
//   collision_cnt_o  saturating collision count
//   stuck_o          sticky stuck-low flags
module uart_hskbus_mux #(
   parameter int unsigned NCHAN        = 4,
   parameter int unsigned CLKS_PER_BIT = 160,
   parameter int unsigned HOLDOFF      = 1550,
   parameter int unsigned CNT_WIDTH    = 8,
   parameter int unsigned STUCK_CLKS   = 3200
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       hskbus_tx_i,
   output logic                       hskbus_rx_o,
   input  logic [NCHAN-1:0]           ch_rx_i,
   output logic [NCHAN-1:0]           ch_tx_o,
   input  logic [NCHAN-1:0]           tx_en_i,
   input  logic [NCHAN-1:0]           rx_en_i,
   input  logic                       stuck_clr_i,
   output logic [CNT_WIDTH-1:0]       tx_bytes_o,
   output logic [NCHAN*CNT_WIDTH-1:0] rx_bytes_o,
   output logic                       collision_o,
   output logic [7:0]                 collision_cnt_o,
   output logic [NCHAN-1:0]           stuck_o
);

   // Line index NCHAN is the host, 0..NCHAN-1 are the channels.
   localparam int NL = int'(NCHAN) + 1;
   // Holdoff never runs past a full frame, so the next start bit is always seen.
   localparam int unsigned FrameClks = 10 * CLKS_PER_BIT;
   localparam int unsigned HoldLoad  = (HOLDOFF < FrameClks) ? HOLDOFF : FrameClks - 1;
   localparam int unsigned HW        = $clog2(HoldLoad + 1);
   localparam logic [HW-1:0] HoldLoadW = HW'(HoldLoad);

   typedef enum logic {StIdle, StHold} det_st_e;

   logic [NCHAN:0] sync1_q, sync2_q;
   logic [NCHAN:0] prev_q, prev_d;
   logic [1:0]     vld_q;
   logic [NCHAN:0] fall, enter, in_hold;

   det_st_e              det_st_q   [NL];
   det_st_e              det_st_d   [NL];
   logic [HW-1:0]        hold_cnt_q [NL];
   logic [HW-1:0]        hold_cnt_d [NL];
   logic [CNT_WIDTH-1:0] byte_cnt_q [NL];
   logic [CNT_WIDTH-1:0] byte_cnt_d [NL];

   logic [NCHAN-1:0] ch_tx_q, ch_tx_d;
   logic             rx_q, rx_d;
   logic             coll, coll_q;
   logic [7:0]       coll_cnt_q, coll_cnt_d;
   logic [NCHAN-1:0] en_enter, en_hold;
   logic [NCHAN-1:0] mask;

   // The sync flops reset to 1, so their first two samples after reset are fill, not line
   // data. prev_q stays 0 until real samples arrive, so a line already low at reset must go
   // high before its next fall can count.
   always_comb begin
      prev_d = vld_q[1] ? sync2_q : '0;
      fall   = prev_q & ~sync2_q;
   end

   always_comb begin
      enter   = '0;
      in_hold = '0;
      for (int i = 0; i < NL; i++) begin
         det_st_d[i]   = det_st_q[i];
         hold_cnt_d[i] = hold_cnt_q[i];
         byte_cnt_d[i] = byte_cnt_q[i];
         unique case (det_st_q[i])
            StIdle: begin
               if (fall[i]) begin
                  enter[i]      = 1'b1;
                  det_st_d[i]   = StHold;
                  hold_cnt_d[i] = HoldLoadW;
                  byte_cnt_d[i] = byte_cnt_q[i] + 1'b1;
               end
            end
            StHold: begin
               in_hold[i]    = 1'b1;
               hold_cnt_d[i] = hold_cnt_q[i] - 1'b1;
               if (hold_cnt_q[i] == HW'(1)) begin
                  det_st_d[i] = StIdle;
               end
            end
            default: det_st_d[i] = StIdle;
         endcase
      end
   end

   // Collision: an enabled channel starts while another enabled channel is holding, or
   // more than one enabled channel starts on the same cycle.
   always_comb begin
      en_enter   = enter[NCHAN-1:0] & rx_en_i;
      en_hold    = in_hold[NCHAN-1:0] & rx_en_i;
      coll       = (|en_enter) && ((|en_hold) || ((en_enter & (en_enter - 1'b1)) != '0));
      coll_cnt_d = coll_cnt_q;
      if (coll && (coll_cnt_q != 8'hFF)) begin
         coll_cnt_d = coll_cnt_q + 8'd1;
      end
   end

   always_comb begin
      ch_tx_d = ~tx_en_i | {NCHAN{sync2_q[NCHAN]}};
      rx_d    = &(sync2_q[NCHAN-1:0] | ~(rx_en_i & ~mask));
   end

`ifdef UART_HSKBUS_STUCK_DET_EN
   localparam int unsigned SW = $clog2(STUCK_CLKS + 1);
   localparam logic [SW-1:0] StuckW = SW'(STUCK_CLKS);

   logic [SW-1:0]    low_cnt_q [NCHAN];
   logic [SW-1:0]    low_cnt_d [NCHAN];
   logic [NCHAN-1:0] stuck_q, stuck_d, mask_q, mask_d;

   always_comb begin
      stuck_d = stuck_q & ~{NCHAN{stuck_clr_i}};
      mask_d  = mask_q;
      for (int k = 0; k < int'(NCHAN); k++) begin
         low_cnt_d[k] = low_cnt_q[k];
         if (sync2_q[k]) begin
            low_cnt_d[k] = '0;
            mask_d[k]    = 1'b0;
         end else if (stuck_clr_i) begin
            low_cnt_d[k] = '0;
         end else if (low_cnt_q[k] != StuckW) begin
            low_cnt_d[k] = low_cnt_q[k] + 1'b1;
            if (low_cnt_q[k] == StuckW - 1'b1) begin
               stuck_d[k] = 1'b1;
               mask_d[k]  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stuck_q <= '0;
         mask_q  <= '0;
         for (int k = 0; k < int'(NCHAN); k++) low_cnt_q[k] <= '0;
      end else begin
         stuck_q <= stuck_d;
         mask_q  <= mask_d;
         for (int k = 0; k < int'(NCHAN); k++) low_cnt_q[k] <= low_cnt_d[k];
      end
   end

   assign mask    = mask_q;
   assign stuck_o = stuck_q;
`else
   logic unused_stuck_clr;
   assign unused_stuck_clr = stuck_clr_i;
   assign mask             = '0;
   assign stuck_o          = '0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q    <= '1;
         sync2_q    <= '1;
         vld_q      <= '0;
         prev_q     <= '0;
         ch_tx_q    <= '1;
         rx_q       <= 1'b1;
         coll_q     <= 1'b0;
         coll_cnt_q <= '0;
         for (int i = 0; i < NL; i++) begin
            det_st_q[i]   <= StIdle;
            hold_cnt_q[i] <= '0;
            byte_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q    <= {hskbus_tx_i, ch_rx_i};
         sync2_q    <= sync1_q;
         vld_q      <= {vld_q[0], 1'b1};
         prev_q     <= prev_d;
         ch_tx_q    <= ch_tx_d;
         rx_q       <= rx_d;
         coll_q     <= coll;
         coll_cnt_q <= coll_cnt_d;
         for (int i = 0; i < NL; i++) begin
            det_st_q[i]   <= det_st_d[i];
            hold_cnt_q[i] <= hold_cnt_d[i];
            byte_cnt_q[i] <= byte_cnt_d[i];
         end
      end
   end

   always_comb begin
      rx_bytes_o = '0;
      for (int k = 0; k < int'(NCHAN); k++) begin
         rx_bytes_o[k*CNT_WIDTH +: CNT_WIDTH] = byte_cnt_q[k];
      end
   end

   assign tx_bytes_o      = byte_cnt_q[NCHAN];
   assign ch_tx_o         = ch_tx_q;
   assign hskbus_rx_o     = rx_q;
   assign collision_o     = coll_q;
   assign collision_cnt_o = coll_cnt_q;

endmodule

// File: tb/tb_uart_hskbus_mux.sv
// Bench for uart_hskbus_mux: randomized UART traffic checked every cycle against a
// behavioural model built from line history (start-bit ages, byte counts, low-run lengths).
module tb_uart_hskbus_mux;

   localparam int unsigned NCHAN   = 4;
   localparam int unsigned CPB     = 8;
   localparam int unsigned HOLDOFF = 70;
   localparam int unsigned CW      = 8;
   localparam int unsigned STUCK   = 160;
   localparam int          NL      = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, tx_pin, hsk_rx, stuck_clr, collision;
   logic [NCHAN-1:0]  ch_pin, ch_tx, tx_en, rx_en, stuck;
   logic [CW-1:0]     tx_bytes;
   logic [NCHAN*CW-1:0] rx_bytes;
   logic [7:0]        coll_cnt;

   uart_hskbus_mux #(
      .NCHAN(NCHAN), .CLKS_PER_BIT(CPB), .HOLDOFF(HOLDOFF), .CNT_WIDTH(CW),
      .STUCK_CLKS(STUCK)
   ) dut (
      .clk_i(clk), .rst_i(rst), .hskbus_tx_i(tx_pin), .hskbus_rx_o(hsk_rx),
      .ch_rx_i(ch_pin), .ch_tx_o(ch_tx), .tx_en_i(tx_en), .rx_en_i(rx_en),
      .stuck_clr_i(stuck_clr), .tx_bytes_o(tx_bytes), .rx_bytes_o(rx_bytes),
      .collision_o(collision), .collision_cnt_o(coll_cnt), .stuck_o(stuck)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [NL-1:0]    m_dly1, m_dly2, m_prev;
   int               m_post;
   int               m_age [NL];
   int               m_cnt [NL];
   int               m_rc  [NCHAN];
   logic [NCHAN-1:0] m_stuck, m_mask;
   logic [NCHAN-1:0] e_ch_tx;
   logic             e_rx, e_coll;
   int               e_ccnt;
   int               cyc_n = 0;

   task automatic model_reset();
      m_dly1 = '1; m_dly2 = '1; m_prev = '0; m_post = 0;
      for (int i = 0; i < NL; i++) begin m_age[i] = 1000000; m_cnt[i] = 0; end
      for (int k = 0; k < int'(NCHAN); k++) m_rc[k] = 0;
      m_stuck = '0; m_mask = '0;
      e_ch_tx = '1; e_rx = 1'b1; e_coll = 1'b0; e_ccnt = 0;
   endtask

   task automatic model_step();
      logic [NL-1:0] s, hold, start;
      int n_es;
      bit en_hold;
      s = m_dly2;  // line value as seen two flops after the pin
      for (int i = 0; i < NL; i++) begin
         if (m_age[i] < 1000000) m_age[i]++;
         hold[i]  = (m_age[i] <= int'(HOLDOFF));
         start[i] = m_prev[i] && !s[i] && !hold[i];
         if (start[i]) begin
            m_cnt[i] = (m_cnt[i] + 1) % 256;
            m_age[i] = 0;
         end
      end
      n_es = 0; en_hold = 0;
      for (int k = 0; k < int'(NCHAN); k++) begin
         if (rx_en[k] && start[k]) n_es++;
         if (rx_en[k] && hold[k]) en_hold = 1;
      end
      e_coll = (n_es >= 2) || (n_es == 1 && en_hold);
      if (e_coll && e_ccnt < 255) e_ccnt++;
      e_rx = 1'b1;
      for (int k = 0; k < int'(NCHAN); k++) begin
         if (rx_en[k] && !m_mask[k] && !s[k]) e_rx = 1'b0;
         e_ch_tx[k] = tx_en[k] ? s[NCHAN] : 1'b1;
      end
`ifdef UART_HSKBUS_STUCK_DET_EN
      for (int k = 0; k < int'(NCHAN); k++) begin
         if (stuck_clr) m_stuck[k] = 1'b0;
         if (s[k]) begin
            m_rc[k] = 0; m_mask[k] = 1'b0;
         end else if (stuck_clr) begin
            m_rc[k] = 0;
         end else begin
            m_rc[k]++;
            if (m_rc[k] == int'(STUCK)) begin m_stuck[k] = 1'b1; m_mask[k] = 1'b1; end
         end
      end
`endif
      // The first two synchronised samples after reset are reset fill, not line data.
      m_prev = (m_post >= 2) ? s : '0;
      if (m_post < 2) m_post++;
      m_dly2 = m_dly1;
      m_dly1 = {tx_pin, ch_pin};
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (rst) model_reset();
         else model_step();
         @(negedge clk);
         cyc_n++;
         check_eq("ch_tx", ch_tx, e_ch_tx);
         check_eq("hsk_rx", hsk_rx, e_rx);
         check_eq("collision", collision, e_coll);
         if (cyc_n % 8 == 0) begin
            check_eq("tx_bytes", tx_bytes, m_cnt[NCHAN][7:0]);
            for (int k = 0; k < int'(NCHAN); k++)
               check_eq($sformatf("rx_bytes%0d", k), rx_bytes[k*CW +: CW], m_cnt[k][7:0]);
            check_eq("coll_cnt", coll_cnt, e_ccnt[7:0]);
            check_eq("stuck", stuck, m_stuck);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic [4:0] sel, input logic v);
      if (sel[4]) tx_pin = v;
      for (int k = 0; k < int'(NCHAN); k++) if (sel[k]) ch_pin[k] = v;
   endtask

   // sel[4] is the host line, sel[3:0] the channels; all selected lines send the same byte.
   task automatic send(input logic [4:0] sel, input logic [7:0] b);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin drive(sel, fr[i]); cyc(CPB); end
   endtask

   task automatic do_reset();
      rst = 1'b1; cyc(3); rst = 1'b0; cyc(4);
   endtask

   initial begin
      logic [7:0] b;
      rst = 1'b1; tx_pin = 1'b1; ch_pin = '1; tx_en = '1; rx_en = '1; stuck_clr = 1'b0;
      cyc(4);
      check_eq("rst_ch_tx", ch_tx, 4'hF);
      check_eq("rst_hsk_rx", hsk_rx, 1);
      check_eq("rst_counts", {tx_bytes, rx_bytes, coll_cnt}, 0);
      check_eq("rst_flags", {collision, stuck}, 0);
      rst = 1'b0; cyc(6);

      // 1: host sends 0x55; broadcast shows the start bit exactly 3 cycles later
      b = 8'h55;
      tx_pin = 1'b0;
      cyc(1); check_eq("lat_c1", ch_tx, 4'hF);
      cyc(1); check_eq("lat_c2", ch_tx, 4'hF);
      cyc(1); check_eq("lat_c3", ch_tx, 4'h0);
      cyc(CPB - 3);
      for (int i = 0; i < 8; i++) begin tx_pin = b[i]; cyc(CPB); end
      tx_pin = 1'b1; cyc(CPB + 20);
      check_eq("t1_tx_bytes", tx_bytes, 1);

      // 2: partial broadcast, 3 bytes, then a glitch inside holdoff
      do_reset();
      tx_en = 4'b0101;
      for (int n = 0; n < 3; n++) send(5'h10, 8'($urandom));
      cyc(20);
      check_eq("t2_tx_bytes", tx_bytes, 3);
      tx_pin = 1'b0; cyc(CPB); tx_pin = 1'b1; cyc(42);
      tx_pin = 1'b0; cyc(3);  tx_pin = 1'b1; cyc(150);
      check_eq("t2_glitch", tx_bytes, 4);

      // 3: ch 2 sends 256 bytes back-to-back; its counter wraps
      do_reset();
      tx_en = '1;
      for (int n = 0; n < 256; n++) send(5'b00100, 8'($urandom));
      cyc(20);
      check_eq("t3_wrap", rx_bytes[2*CW +: CW], 0);
      check_eq("t3_others", {rx_bytes[3*CW +: CW], rx_bytes[CW-1:0], rx_bytes[CW +: CW]}, 0);

      // 4: simultaneous starts on ch 0/1, then with ch 1 merge disabled, then staggered
      do_reset();
      send(5'b00011, 8'($urandom)); cyc(10);
      check_eq("t4_coll_cnt", coll_cnt, 1);
      check_eq("t4_rx0", rx_bytes[CW-1:0], 1);
      check_eq("t4_rx1", rx_bytes[CW +: CW], 1);
      rx_en = 4'b1101;
      send(5'b00011, 8'($urandom)); cyc(10);
      check_eq("t4_no_coll", coll_cnt, 1);
      rx_en = '1;
      ch_pin[0] = 1'b0; cyc(CPB); ch_pin[0] = 1'b1; cyc(4);
      ch_pin[1] = 1'b0; cyc(CPB); ch_pin[1] = 1'b1; cyc(150);
      check_eq("t4_hold_coll", coll_cnt, 2);

      // 5: ch 3 stuck low
      do_reset();
      ch_pin[3] = 1'b0; cyc(STUCK + 20);
`ifdef UART_HSKBUS_STUCK_DET_EN
      check_eq("t5_stuck", stuck, 4'b1000);
      check_eq("t5_masked", hsk_rx, 1);
`else
      check_eq("t5_stuck", stuck, 4'b0000);
      check_eq("t5_masked", hsk_rx, 0);
`endif
      ch_pin[3] = 1'b1; cyc(10);
      stuck_clr = 1'b1; cyc(1); stuck_clr = 1'b0; cyc(3);
      check_eq("t5_clr", stuck, 0);
      ch_pin[3] = 1'b0; cyc(STUCK + 10);
      stuck_clr = 1'b1; cyc(1); stuck_clr = 1'b0; cyc(2);
      check_eq("t5_clr_low", stuck, 0);
      cyc(STUCK);
      ch_pin[3] = 1'b1; cyc(20);

      // 6: reset in the middle of a ch 0 byte of zeros
      do_reset();
      ch_pin[0] = 1'b0; cyc(25);
      rst = 1'b1; cyc(3); rst = 1'b0;
      cyc(10 * CPB - 28); ch_pin[0] = 1'b1; cyc(20);
      check_eq("t6_after_rst", rx_bytes[CW-1:0], 0);
      send(5'b00001, 8'($urandom)); cyc(10);
      check_eq("t6_next", rx_bytes[CW-1:0], 1);

      // 7: random traffic with random enables
      for (int n = 0; n < 40; n++) begin
         tx_en = 4'($urandom); rx_en = 4'($urandom);
         send(5'($urandom), 8'($urandom));
         cyc($urandom_range(0, 30));
      end

      // 8: collision counter saturation
      rx_en = '1;
      for (int n = 0; n < 260; n++) begin
         ch_pin[1:0] = 2'b00; cyc(4); ch_pin[1:0] = 2'b11; cyc(HOLDOFF + 6);
      end
      check_eq("t8_sat", coll_cnt, 255);
      cyc(16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
